// File: rtl/audio_sample_conditioner.sv
// Codec-to-ColorChord sample conditioner: L+R sum, DC-blocking high-pass, optional
// averaging decimation, 16-bit saturation, valid/taken output, peak-hold meter.
module audio_sample_conditioner #(
    parameter int DC_SHIFT         = 10,
    parameter int DEC_LOG2         = 0,
    parameter int METER_DECAY_LOG2 = 20
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        read_ready,
    input  logic [23:0] readdata_left,
    input  logic [23:0] readdata_right,
    output logic        read,
    output logic [15:0] sampleOut,
    output logic        sampleValid,
    input  logic        sampleTaken,
    output logic [9:0]  level,
    output logic        overrun
);
    localparam int DW = 26 + DEC_LOG2;

    typedef enum logic [1:0] {IDLE, FILTER, EMIT} state_t;
    state_t state, state_next;

    logic [23:0]                  left_q, right_q;
    logic signed [24:0]           x;
    logic signed [25:0]           y, y_q;
    logic signed [DW-1:0]         dsum, dsum_next;
    logic [4:0]                   dcnt;
    logic                         dec_wrap, emit_out;
    logic signed [25:0]           d;
    logic signed [17:0]           s;
    logic signed [15:0]           s_sat;
    logic [15:0]                  mag;
    logic [9:0]                   m;
    logic [METER_DECAY_LOG2-1:0]  decay_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read_ready) state_next = FILTER;
            FILTER:  state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb read = (state == IDLE) && read_ready && !reset;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            left_q  <= '0;
            right_q <= '0;
        end else if (read) begin
            left_q  <= readdata_left;
            right_q <= readdata_right;
        end
    end

    always_comb x = $signed({left_q[23], left_q}) + $signed({right_q[23], right_q});

    if (DC_SHIFT > 0) begin : g_dc
        logic signed [25+DC_SHIFT:0] acc;
        logic signed [25:0]          est;
        always_comb begin
            est = 26'(acc >>> DC_SHIFT);
            y   = $signed({x[24], x}) - est;
        end
        always_ff @(posedge CLOCK_50) begin
            if (reset)                 acc <= '0;
            else if (state == FILTER)  acc <= acc + {{DC_SHIFT{y[25]}}, y};
        end
    end else begin : g_bypass
        always_comb y = $signed({x[24], x});
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)                y_q <= '0;
        else if (state == FILTER) y_q <= y;
    end

    // The output path sees the running sum including the current sample.
    always_comb begin
        dsum_next = dsum + DW'(y_q);
        dec_wrap  = (dcnt == 5'((1 << DEC_LOG2) - 1));
        emit_out  = (state == EMIT) && dec_wrap;
        d         = 26'(dsum_next >>> DEC_LOG2);
        s         = 18'(d >>> 8);
        if (s > 18'sd32767)       s_sat = 16'sh7fff;
        else if (s < -18'sd32768) s_sat = 16'sh8000;
        else                      s_sat = s[15:0];
        mag = s_sat[15] ? 16'(-s_sat) : 16'(s_sat);
        m   = (s_sat == 16'sh8000) ? 10'd511 : mag[15:6];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dsum <= '0;
            dcnt <= '0;
        end else if (state == EMIT) begin
            if (dec_wrap) begin
                dsum <= '0;
                dcnt <= '0;
            end else begin
                dsum <= dsum_next;
                dcnt <= dcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            overrun     <= 1'b0;
        end else if (emit_out) begin
            sampleOut   <= s_sat;
            sampleValid <= 1'b1;
            if (sampleValid && !sampleTaken) overrun <= 1'b1;
        end else if (sampleValid && sampleTaken) begin
            sampleValid <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            decay_cnt <= '0;
            level     <= '0;
        end else begin
            decay_cnt <= decay_cnt + 1'b1;
            if (emit_out && m > level)            level <= m;
            else if (&decay_cnt && level != '0)   level <= level - 10'd1;
        end
    end
endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Bench for audio_sample_conditioner: three parameterisations share one stimulus and
// are checked every cycle against an arithmetic reference model.
module tb_audio_sample_conditioner;
    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic              reset = 1'b1;
    logic              read_ready = 1'b1;
    logic              sampleTaken = 1'b0;
    logic [23:0]       l_in = '0;
    logic [23:0]       r_in = '0;
    logic [2:0]        rd, sv, ov;
    logic [2:0][15:0]  so;
    logic [2:0][9:0]   lv;

    audio_sample_conditioner #(.DC_SHIFT(0), .DEC_LOG2(0), .METER_DECAY_LOG2(4)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .read_ready(read_ready),
        .readdata_left(l_in), .readdata_right(r_in), .read(rd[0]),
        .sampleOut(so[0]), .sampleValid(sv[0]), .sampleTaken(sampleTaken),
        .level(lv[0]), .overrun(ov[0]));

    audio_sample_conditioner #(.DC_SHIFT(4), .DEC_LOG2(0), .METER_DECAY_LOG2(4)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .read_ready(read_ready),
        .readdata_left(l_in), .readdata_right(r_in), .read(rd[1]),
        .sampleOut(so[1]), .sampleValid(sv[1]), .sampleTaken(sampleTaken),
        .level(lv[1]), .overrun(ov[1]));

    audio_sample_conditioner #(.DC_SHIFT(0), .DEC_LOG2(2), .METER_DECAY_LOG2(20)) dut_c (
        .CLOCK_50(CLOCK_50), .reset(reset), .read_ready(read_ready),
        .readdata_left(l_in), .readdata_right(r_in), .read(rd[2]),
        .sampleOut(so[2]), .sampleValid(sv[2]), .sampleTaken(sampleTaken),
        .level(lv[2]), .overrun(ov[2]));

    int     dcs  [3] = '{0, 4, 0};
    int     decs [3] = '{0, 0, 2};
    int     mlog [3] = '{4, 4, 20};

    longint acc [3], dsum [3];
    int     dcnt [3], pend_s [3], m_sout [3], m_level [3];
    bit     pend [3], m_valid [3], m_ovr [3];
    int     since_pop = 3;
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int meter(input int sv_in);
        if (sv_in == -32768) return 511;
        return (sv_in < 0 ? -sv_in : sv_in) / 64;
    endfunction

    task automatic model_sample(input int i, input longint x);
        longint y, dv, sval;
        y = (dcs[i] == 0) ? x : x - (acc[i] >>> dcs[i]);
        if (dcs[i] > 0) acc[i] += y;
        dsum[i] += y;
        dcnt[i]++;
        if (dcnt[i] == (1 << decs[i])) begin
            dv      = dsum[i] >>> decs[i];
            dsum[i] = 0;
            dcnt[i] = 0;
            sval    = dv >>> 8;
            if (sval > 32767)  sval = 32767;
            if (sval < -32768) sval = -32768;
            pend[i]   = 1'b1;
            pend_s[i] = int'(sval);
        end
    endtask

    // Sample emerges three cycles after its pop, together with that cycle's taken.
    task automatic model_step();
        bit     emit, newo, tick;
        int     mv;
        longint per, x;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                acc[i] = 0; dsum[i] = 0; dcnt[i] = 0; pend[i] = 0;
                m_sout[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_level[i] = 0;
            end
            since_pop = 3;
            cyc = 0;
        end else begin
            emit = (since_pop == 2);
            for (int i = 0; i < 3; i++) begin
                per  = longint'(1) << mlog[i];
                tick = ((cyc % per) == per - 1);
                newo = emit && pend[i];
                mv   = meter(pend_s[i]);
                if (newo) begin
                    pend[i] = 1'b0;
                    if (m_valid[i] && !sampleTaken) m_ovr[i] = 1'b1;
                    m_valid[i] = 1'b1;
                    m_sout[i]  = pend_s[i];
                end else if (m_valid[i] && sampleTaken) begin
                    m_valid[i] = 1'b0;
                end
                if (newo && mv > m_level[i])       m_level[i] = mv;
                else if (tick && m_level[i] > 0)   m_level[i]--;
            end
            cyc++;
            if (read_ready && since_pop >= 3) begin
                x = longint'($signed(l_in)) + longint'($signed(r_in));
                for (int i = 0; i < 3; i++) model_sample(i, x);
                since_pop = 1;
            end else if (since_pop < 3) begin
                since_pop++;
            end
        end
    endtask

    always @(posedge CLOCK_50) model_step();

    always @(negedge CLOCK_50) begin
        bit er;
        er = !reset && read_ready && (since_pop >= 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("read[%0d]", i), rd[i], er);
            chk($sformatf("sampleOut[%0d]", i), longint'($signed(so[i])), m_sout[i]);
            chk($sformatf("sampleValid[%0d]", i), sv[i], m_valid[i]);
            chk($sformatf("level[%0d]", i), lv[i], m_level[i]);
            chk($sformatf("overrun[%0d]", i), ov[i], m_ovr[i]);
        end
    end

    task automatic after_posedge(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input int n);
        after_posedge(1);
        read_ready = 1'b0;
        reset = 1'b1;
        after_posedge(n);
        reset = 1'b0;
    endtask

    // Returns just after the edge that ends the pop cycle.
    task automatic pop_one(input logic [23:0] l, input logic [23:0] r);
        bit got;
        after_posedge(1);
        l_in = l;
        r_in = r;
        read_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge CLOCK_50);
            got = rd[0];
        end
        chk("pop_seen", got, 1);
        after_posedge(1);
        read_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint prev, s;
        int     n, nreads;

        l_in = 24'h7FFFFF;
        r_in = 24'h7FFFFF;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset_read", rd, 0);
        chk("reset_valid", sv, 0);
        chk("reset_out_a", so[0], 0);
        chk("reset_level_a", lv[0], 0);
        chk("reset_ovr", ov, 0);
        after_posedge(1);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("first_read_after_release", rd[0], 1);
        after_posedge(1);
        read_ready = 1'b0;
        wait_neg(3);
        chk("sat_pos_a", longint'($signed(so[0])), 32767);
        chk("sat_pos_b", longint'($signed(so[1])), 32767);
        chk("sat_pos_level", lv[0], 511);
        chk("sat_pos_model", m_sout[0], 32767);

        do_reset(2);
        pop_one(24'h800000, 24'h800000);
        wait_neg(3);
        chk("sat_neg_a", longint'($signed(so[0])), -32768);
        chk("sat_neg_level", lv[0], 511);
        chk("sat_neg_model", m_sout[0], -32768);

        do_reset(2);
        pop_one(24'h001000, 24'h000000);
        wait_neg(3);
        chk("left_only_a", longint'($signed(so[0])), 16);
        chk("left_only_model", m_sout[0], 16);

        // Continuous read_ready: DC removal on instance B, pop spacing on A.
        do_reset(2);
        l_in = 24'h001000;
        r_in = 24'h001000;
        sampleTaken = 1'b1;
        read_ready = 1'b1;
        nreads = 0;
        @(negedge CLOCK_50);
        nreads += int'(rd[0]);
        for (int j = 0; j < 3; j++) begin
            @(negedge CLOCK_50);
            nreads += int'(rd[0]);
        end
        prev = longint'($signed(so[1]));
        chk("dc_first", prev, 32);
        chk("dc_first_model", m_sout[1], 32);
        for (int k = 1; k < 210; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge CLOCK_50);
                nreads += int'(rd[0]);
            end
            s = longint'($signed(so[1]));
            chk("dc_monotonic", (s <= prev), 1);
            prev = s;
        end
        chk("dc_settled", (prev <= 1 && prev >= -1), 1);
        chk("read_every_3", nreads, 211);
        after_posedge(1);
        read_ready = 1'b0;
        sampleTaken = 1'b0;

        do_reset(2);
        for (int k = 1; k <= 4; k++) begin
            pop_one(24'(256 * k), 24'h0);
            wait_neg(3);
            if (k < 4) chk("dec_no_valid", sv[2], 0);
        end
        chk("dec_valid", sv[2], 1);
        chk("dec_value", longint'($signed(so[2])), 2);
        chk("dec_model", m_sout[2], 2);

        do_reset(2);
        pop_one(24'h001000, 24'h0);
        wait_neg(3);
        chk("hs_valid_first", sv[0], 1);
        chk("hs_ovr_first", ov[0], 0);
        pop_one(24'h002000, 24'h0);
        wait_neg(3);
        chk("hs_replaced", longint'($signed(so[0])), 32);
        chk("hs_overrun", ov[0], 1);
        after_posedge(1);
        sampleTaken = 1'b1;
        @(negedge CLOCK_50);
        chk("hs_valid_during_taken", sv[0], 1);
        after_posedge(1);
        @(negedge CLOCK_50);
        chk("hs_valid_cleared", sv[0], 0);
        after_posedge(3);
        sampleTaken = 1'b0;
        chk("hs_overrun_sticky", ov[0], 1);
        chk("hs_out_held", longint'($signed(so[0])), 32);

        do_reset(2);
        pop_one(24'h001000, 24'h0);
        wait_neg(3);
        pop_one(24'h003000, 24'h0);
        after_posedge(1);
        sampleTaken = 1'b1;
        after_posedge(1);
        sampleTaken = 1'b0;
        @(negedge CLOCK_50);
        chk("same_cycle_valid", sv[0], 1);
        chk("same_cycle_ovr", ov[0], 0);
        chk("same_cycle_value", longint'($signed(so[0])), 48);

        do_reset(2);
        sampleTaken = 1'b1;
        pop_one(24'h190000, 24'h0);
        wait_neg(3);
        chk("meter_load", lv[0], 100);
        chk("meter_model", m_level[0], 100);
        n = 0;
        while (lv[0] != 99 && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("meter_first_decay", (n <= 16), 1);
        while (lv[0] != 0 && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("meter_to_zero", (n <= 1616), 1);
        pop_one(24'h320000, 24'h0);
        wait_neg(3);
        chk("meter_reload", lv[0], 200);
        sampleTaken = 1'b0;

        do_reset(2);
        for (int k = 0; k < 500; k++) begin
            after_posedge(1);
            read_ready  = ($urandom_range(0, 3) != 0);
            l_in        = 24'($urandom);
            r_in        = 24'($urandom);
            sampleTaken = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 99) == 0);
        end
        after_posedge(1);
        reset = 1'b0;
        read_ready = 1'b0;
        after_posedge(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
